// File: rtl/coax_pkg.sv
// Shared definitions for the coax receive path: word width, error codes
// reported on error_code, and the receive-buffer state encoding.
package coax_pkg;

   localparam int unsigned WORD_WIDTH = 10;

   localparam logic [WORD_WIDTH-1:0] LOSS_OF_MID_BIT_TRANSITION_ERROR = 10'h001;
   localparam logic [WORD_WIDTH-1:0] PARITY_ERROR                     = 10'h002;
   localparam logic [WORD_WIDTH-1:0] OVERFLOW_ERROR                   = 10'h004;

   typedef enum logic [1:0] {
      IDLE,
      RECEIVING,
      ERROR
   } buf_state_t;

endpackage

// File: rtl/coax_fifo.sv
// First-word-fall-through storage with read/write pointers and an occupancy
// count. push/pop are assumed already qualified by the caller (no push when
// full without a pop, no pop when empty). clear flushes synchronously.
module coax_fifo #(
   parameter  int unsigned WIDTH     = 10,
   parameter  int unsigned DEPTH     = 8,
   localparam int unsigned PTR_WIDTH = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 push,
   input  logic                 pop,
   input  logic [WIDTH-1:0]     wdata,
   output logic [WIDTH-1:0]     rdata,
   output logic                 empty,
   output logic                 full,
   output logic [PTR_WIDTH:0]   count
);

   localparam int unsigned CW = PTR_WIDTH + 1;

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [PTR_WIDTH-1:0] wr_ptr;
   logic [PTR_WIDTH-1:0] rd_ptr;

   // Pointer and occupancy tracking; pointers wrap naturally modulo DEPTH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array write; contents need no reset since empty masks them.
   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/coax_rx_buffer.sv
// Host-side receive buffer behind coax_rx: captures strobed words into a
// FWFT FIFO, tracks message activity, and latches receiver/overflow errors.
// Optional macro COAX_RX_BUFFER_FRAME_MARK_EN adds a first-of-frame bit per
// entry, exposed as data_first alongside the head word.
module coax_rx_buffer
   import coax_pkg::*;
#(
   parameter  int unsigned DEPTH     = 8,
   localparam int unsigned PTR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx_active,
   input  logic                  rx_strobe,
   input  logic                  rx_error,
   input  logic [WORD_WIDTH-1:0] rx_data,
   output logic                  rx_reset,
   input  logic                  clear,
   input  logic                  read_strobe,
   output logic [WORD_WIDTH-1:0] data,
   output logic                  empty,
   output logic                  full,
   output logic [PTR_WIDTH:0]    depth,
   output logic                  active,
   output logic                  error,
   output logic [WORD_WIDTH-1:0] error_code
`ifdef COAX_RX_BUFFER_FRAME_MARK_EN
   ,
   output logic                  data_first
`endif
);

`ifdef COAX_RX_BUFFER_FRAME_MARK_EN
   localparam int unsigned DW = WORD_WIDTH + 1;
`else
   localparam int unsigned DW = WORD_WIDTH;
`endif

   buf_state_t    state;
   logic          pop_ok;
   logic          accept;
   logic          push;
   logic          overflow;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;

   // Qualify host pops and receiver pushes; clear and rx_error pre-empt writes.
   always_comb begin
      pop_ok   = read_strobe && !empty && !clear;
      accept   = (state != ERROR) && rx_strobe && !rx_error && !clear;
      push     = accept && (!full || pop_ok);
      overflow = accept && full && !pop_ok;
   end

`ifdef COAX_RX_BUFFER_FRAME_MARK_EN
   logic first_pending;
   logic first_flag;

   // The first word of a frame may arrive in the same cycle as the IDLE->RECEIVING edge.
   always_comb begin
      first_flag = first_pending || ((state == IDLE) && rx_active);
      wdata      = {first_flag, rx_data};
   end

   // Arm the first-of-frame mark on message start; consume it on the first write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         first_pending <= 1'b0;
      end else if (clear) begin
         first_pending <= 1'b0;
      end else if (push) begin
         first_pending <= 1'b0;
      end else if ((state == IDLE) && rx_active && !rx_error) begin
         first_pending <= 1'b1;
      end else if ((state == RECEIVING) && !rx_active) begin
         first_pending <= 1'b0;
      end
   end

   assign data       = rdata[WORD_WIDTH-1:0];
   assign data_first = rdata[WORD_WIDTH];
`else
   assign wdata = rx_data;
   assign data  = rdata;
`endif

   coax_fifo #(
      .WIDTH (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .push  (push),
      .pop   (pop_ok),
      .wdata (wdata),
      .rdata (rdata),
      .empty (empty),
      .full  (full),
      .count (depth)
   );

   // Buffer state machine with registered active, error and rx_reset outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         active     <= 1'b0;
         error      <= 1'b0;
         error_code <= '0;
         rx_reset   <= 1'b0;
      end else begin
         rx_reset <= clear;
         if (clear) begin
            state      <= IDLE;
            active     <= 1'b0;
            error      <= 1'b0;
            error_code <= '0;
         end else if (state != ERROR) begin
            if (rx_error) begin
               state      <= ERROR;
               active     <= 1'b0;
               error      <= 1'b1;
               error_code <= rx_data;
            end else if (overflow) begin
               state      <= ERROR;
               active     <= 1'b0;
               error      <= 1'b1;
               error_code <= OVERFLOW_ERROR;
            end else if ((state == IDLE) && rx_active) begin
               state  <= RECEIVING;
               active <= 1'b1;
            end else if ((state == RECEIVING) && !rx_active) begin
               state  <= IDLE;
               active <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_coax_rx_buffer.sv
// Directed self-checking bench for coax_rx_buffer (DEPTH=8).
module tb_coax_rx_buffer;
   import coax_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx_active = 1'b0;
   logic       rx_strobe = 1'b0;
   logic       rx_error = 1'b0;
   logic [9:0] rx_data = '0;
   logic       rx_reset;
   logic       clear = 1'b0;
   logic       read_strobe = 1'b0;
   logic [9:0] data;
   logic       empty;
   logic       full;
   logic [3:0] depth;
   logic       active;
   logic       error;
   logic [9:0] error_code;
`ifdef COAX_RX_BUFFER_FRAME_MARK_EN
   logic       data_first;
`endif

   int unsigned checks = 0;
   int unsigned failures = 0;

   coax_rx_buffer #(.DEPTH(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_active   (rx_active),
      .rx_strobe   (rx_strobe),
      .rx_error    (rx_error),
      .rx_data     (rx_data),
      .rx_reset    (rx_reset),
      .clear       (clear),
      .read_strobe (read_strobe),
      .data        (data),
      .empty       (empty),
      .full        (full),
      .depth       (depth),
      .active      (active),
      .error       (error),
      .error_code  (error_code)
`ifdef COAX_RX_BUFFER_FRAME_MARK_EN
      ,
      .data_first  (data_first)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [9:0] w);
      rx_strobe = 1'b1;
      rx_data   = w;
      step();
      rx_strobe = 1'b0;
   endtask

   task automatic read_expect(input string tag, input logic [9:0] w);
      check(tag, data, w);
      read_strobe = 1'b1;
      step();
      read_strobe = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   initial begin
      // Reset state
      step();
      step();
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_depth", depth, 0);
      check("rst_active", active, 0);
      check("rst_error", error, 0);
      check("rst_code", error_code, 0);
      check("rst_rxreset", rx_reset, 0);
      reset = 1'b0;
      step();

      // 1: three words in order
      write_word(10'h2B3);
      check("t1_empty_after_one", empty, 0);
      check("t1_depth_after_one", depth, 1);
      write_word(10'h001);
      write_word(10'h3FF);
      check("t1_depth", depth, 3);
      read_expect("t1_rd0", 10'h2B3);
      read_expect("t1_rd1", 10'h001);
      read_expect("t1_rd2", 10'h3FF);
      check("t1_empty", empty, 1);

      // Read while empty is ignored
      read_strobe = 1'b1;
      step();
      read_strobe = 1'b0;
      check("rd_empty_depth", depth, 0);
      check("rd_empty_error", error, 0);

      // 2: fill, overflow, drain
      for (int i = 0; i < 8; i++) write_word(10'h100 + 10'(i));
      check("t2_full", full, 1);
      check("t2_depth", depth, 8);
      check("t2_err_before", error, 0);
      write_word(10'h3AA);
      check("t2_error", error, 1);
      check("t2_code", error_code, 10'h004);
      check("t2_depth_after", depth, 8);
      write_word(10'h3BB);
      check("t2_blocked", depth, 8);
      for (int i = 0; i < 8; i++) read_expect("t2_rd", 10'h100 + 10'(i));
      check("t2_empty", empty, 1);
      do_clear();
      check("t2_clr_rxreset", rx_reset, 1);
      check("t2_clr_error", error, 0);
      step();
      check("t2_rxreset_off", rx_reset, 0);

      // 3: simultaneous push and pop while full
      for (int i = 0; i < 8; i++) write_word(10'h200 + 10'(i));
      rx_strobe = 1'b1;
      rx_data = 10'h2FF;
      read_strobe = 1'b1;
      step();
      rx_strobe = 1'b0;
      read_strobe = 1'b0;
      check("t3_depth", depth, 8);
      check("t3_error", error, 0);
      check("t3_full", full, 1);
      for (int i = 1; i < 8; i++) read_expect("t3_rd", 10'h200 + 10'(i));
      read_expect("t3_last", 10'h2FF);
      check("t3_empty", empty, 1);

      // 4: receiver error during message
      rx_active = 1'b1;
      step();
      check("t4_active", active, 1);
      rx_error = 1'b1;
      rx_data = PARITY_ERROR;
      rx_strobe = 1'b1;
      step();
      rx_error = 1'b0;
      rx_strobe = 1'b0;
      check("t4_active_off", active, 0);
      check("t4_error", error, 1);
      check("t4_code", error_code, 10'h002);
      check("t4_strobe_ignored", depth, 0);
      write_word(10'h055);
      check("t4_not_stored", empty, 1);
      rx_active = 1'b0;
      do_clear();
      step();

      // 5: clear while in ERROR with two words stored
      write_word(10'h0A1);
      write_word(10'h0A2);
      rx_error = 1'b1;
      rx_data = LOSS_OF_MID_BIT_TRANSITION_ERROR;
      step();
      rx_error = 1'b0;
      check("t5_error", error, 1);
      check("t5_code", error_code, 10'h001);
      check("t5_depth", depth, 2);
      check("t5_head", data, 10'h0A1);
      check("t5_rxreset_pre", rx_reset, 0);
      do_clear();
      check("t5_rxreset", rx_reset, 1);
      check("t5_empty", empty, 1);
      check("t5_depth0", depth, 0);
      check("t5_error_off", error, 0);
      check("t5_code_off", error_code, 0);
      step();
      check("t5_rxreset_once", rx_reset, 0);
      write_word(10'h0C3);
      check("t5_idle_write", depth, 1);
      read_expect("t5_idle_rd", 10'h0C3);

      // 6: pointer wrap with interleaved write/read pairs
      rx_active = 1'b1;
      for (int i = 0; i < 20; i++) begin
         write_word(10'(i));
         check("t6_depth1", depth, 1);
`ifdef COAX_RX_BUFFER_FRAME_MARK_EN
         check("t6_first", data_first, (i == 0) ? 1 : 0);
`endif
         read_expect("t6_rd", 10'(i));
         check("t6_depth0", depth, 0);
      end
      rx_active = 1'b0;
      step();
      check("t6_active_off", active, 0);

      // Asynchronous reset mid-operation
      write_word(10'h111);
      write_word(10'h222);
      #2;
      reset = 1'b1;
      #1;
      check("ar_depth", depth, 0);
      check("ar_empty", empty, 1);
      check("ar_rxreset", rx_reset, 0);
      step();
      reset = 1'b0;
      step();
      check("ar_error", error, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
